traffic_light_monitor: RTL and testbench

- Passive checker on the far side of the traffic_light lamp interface. It samples r/y/g every cycle and decodes them into a phase.
- Checks legal phase order (RED -> GREEN -> YELLOW -> RED) and per-phase dwell time against WAIT.
- Counts completed light cycles and reports error pulses plus a sticky error flag.
- Sits beside traffic_light in the same clock domain, in-system or as a bench checker.

---
 rtl/traffic_light_monitor.sv | 149 ++++++++++++++
 tb/tb_traffic_light_monitor.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker for the r/y/g lamp interface of traffic_light.
// Decodes the lamps into a phase, checks RED->GREEN->YELLOW->RED order and per-phase
// dwell against WAIT, counts completed light cycles and flags errors.
// Optional build macro TL_MON_CAPTURE_EN adds err_phase/err_code first-error capture.
module traffic_light_monitor #(
  parameter int unsigned WAIT = 32'd5,
  parameter int unsigned CW   = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r,
  input  logic          y,
  input  logic          g,
  input  logic          clr,
  output logic [1:0]    phase,
  output logic [CW-1:0] dwell_cnt,
  output logic          phase_chg,
  output logic          err_onehot,
  output logic          err_seq,
  output logic          err_timing,
  output logic          err_sticky,
  output logic [15:0]   cycle_cnt
`ifdef TL_MON_CAPTURE_EN
  ,
  output logic [1:0]    err_phase,
  output logic [2:0]    err_code
`endif
);

  typedef enum logic [1:0] {
    PhIdle   = 2'b00,
    PhRed    = 2'b01,
    PhGreen  = 2'b10,
    PhYellow = 2'b11
  } phase_e;

  localparam logic [CW-1:0] DwellMax = '1;
  localparam logic [CW-1:0] WaitCw   = CW'(WAIT);

  phase_e        state_q, state_d, lamp;
  logic          lamp_valid;
  logic          exempt_q, exempt_d;
  logic [CW-1:0] dwell_d;
  logic          chg_d, eoh_d, eseq_d, etim_d, any_err;
  logic          legal;
  logic          cyc_inc;
  logic [15:0]   cycle_d;
  logic          sticky_d;

  assign phase = state_q;

  // Decode the raw lamps; only an exactly one-hot pattern names a phase.
  always_comb begin
    lamp       = PhIdle;
    lamp_valid = 1'b0;
    unique case ({r, y, g})
      3'b100:  begin lamp = PhRed;    lamp_valid = 1'b1; end
      3'b010:  begin lamp = PhYellow; lamp_valid = 1'b1; end
      3'b001:  begin lamp = PhGreen;  lamp_valid = 1'b1; end
      default: begin lamp = PhIdle;   lamp_valid = 1'b0; end
    endcase
  end

  // Next phase, dwell, exemption and error pulses from the current sample.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_cnt;
    exempt_d = exempt_q;
    chg_d    = 1'b0;
    eoh_d    = 1'b0;
    eseq_d   = 1'b0;
    etim_d   = 1'b0;
    cyc_inc  = 1'b0;
    legal    = ((state_q == PhRed)    && (lamp == PhGreen))  ||
               ((state_q == PhGreen)  && (lamp == PhYellow)) ||
               ((state_q == PhYellow) && (lamp == PhRed));
    if (!lamp_valid) begin
      eoh_d    = 1'b1;
      state_d  = PhIdle;
      dwell_d  = '0;
      exempt_d = 1'b1;
    end else if (state_q == PhIdle) begin
      // Entry from IDLE: dwell of this phase is unknowable, so skip its exit timing check.
      state_d  = lamp;
      dwell_d  = CW'(1);
      chg_d    = 1'b1;
      exempt_d = 1'b1;
    end else if (lamp == state_q) begin
      if (dwell_cnt != DwellMax) dwell_d = dwell_cnt + CW'(1);
      // Fires once: dwell only passes through WAIT a single time per phase.
      if (!exempt_q && (dwell_cnt == WaitCw)) etim_d = 1'b1;
    end else begin
      state_d  = lamp;
      dwell_d  = CW'(1);
      chg_d    = 1'b1;
      eseq_d   = !legal;
      exempt_d = !legal;
      if (!exempt_q && (dwell_cnt < WaitCw)) etim_d = 1'b1;
      if (legal && (state_q == PhYellow)) cyc_inc = 1'b1;
    end
  end

  assign any_err  = eoh_d | eseq_d | etim_d;
  // Error set wins over clr; increment wins over clr (restarting from zero).
  assign sticky_d = any_err | (err_sticky & ~clr);
  assign cycle_d  = cyc_inc ? (clr ? 16'd1 : cycle_cnt + 16'd1) : (clr ? 16'd0 : cycle_cnt);

  // Register all state and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= PhIdle;
      dwell_cnt  <= '0;
      exempt_q   <= 1'b1;
      phase_chg  <= 1'b0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      err_timing <= 1'b0;
      err_sticky <= 1'b0;
      cycle_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      dwell_cnt  <= dwell_d;
      exempt_q   <= exempt_d;
      phase_chg  <= chg_d;
      err_onehot <= eoh_d;
      err_seq    <= eseq_d;
      err_timing <= etim_d;
      err_sticky <= sticky_d;
      cycle_cnt  <= cycle_d;
    end
  end

`ifdef TL_MON_CAPTURE_EN
  // Capture the phase being checked and the error kinds at the first error since reset/clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_phase <= 2'b00;
      err_code  <= 3'b000;
    end else if (any_err && (!err_sticky || clr)) begin
      err_phase <= state_q;
      err_code  <= {etim_d, eseq_d, eoh_d};
    end else if (clr) begin
      err_phase <= 2'b00;
      err_code  <= 3'b000;
    end
  end
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with WAIT=5; expected values worked out by hand.
module tb_traffic_light_monitor;

  localparam int unsigned Wait = 5;
  localparam int unsigned Cw   = 32;

  localparam logic [2:0] LR = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LG = 3'b001;
  localparam logic [2:0] LRG = 3'b101;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          r = 1'b0, y = 1'b0, g = 1'b0, clr = 1'b0;
  logic [1:0]    phase;
  logic [Cw-1:0] dwell_cnt;
  logic          phase_chg, err_onehot, err_seq, err_timing, err_sticky;
  logic [15:0]   cycle_cnt;

  int pass_cnt = 0;
  int total    = 0;
  int chg_seen = 0;
  int err_seen = 0;

  always #5 clk = ~clk;

  traffic_light_monitor #(.WAIT(Wait), .CW(Cw)) dut (
    .clk(clk), .rst(rst), .r(r), .y(y), .g(g), .clr(clr),
    .phase(phase), .dwell_cnt(dwell_cnt), .phase_chg(phase_chg),
    .err_onehot(err_onehot), .err_seq(err_seq), .err_timing(err_timing),
    .err_sticky(err_sticky), .cycle_cnt(cycle_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Apply one lamp sample, clock it in, and look at the outputs 1ns after the edge.
  task automatic drive(input logic [2:0] lamp, input logic c = 1'b0);
    {r, y, g} = lamp;
    clr = c;
    @(posedge clk);
    #1;
    chg_seen += int'(phase_chg);
    err_seen += int'(err_onehot | err_seq | err_timing);
  endtask

  initial begin
    #2;
    check("rst_phase", 32'(phase), 0);
    check("rst_dwell", dwell_cnt, 0);
    check("rst_cycle", 32'(cycle_cnt), 0);
    check("rst_sticky", 32'(err_sticky), 0);
    #10 rst = 1'b1;

    // One full legal cycle R5 G5 Y5 R5.
    drive(LR);
    check("c1_r_phase", 32'(phase), 1);
    check("c1_r_dwell", dwell_cnt, 1);
    for (int i = 0; i < 4; i++) drive(LR);
    check("c1_r_dwell5", dwell_cnt, 5);
    drive(LG);
    check("c1_g_phase", 32'(phase), 2);
    for (int i = 0; i < 4; i++) drive(LG);
    drive(LY);
    check("c1_y_phase", 32'(phase), 3);
    for (int i = 0; i < 4; i++) drive(LY);
    drive(LR);
    check("c1_r2_phase", 32'(phase), 1);
    check("c1_cycle", 32'(cycle_cnt), 1);
    for (int i = 0; i < 4; i++) drive(LR);
    check("c1_chg_count", chg_seen, 4);
    check("c1_no_err", err_seen, 0);
    check("c1_sticky", 32'(err_sticky), 0);

    // Short GREEN: timing error on the G->Y edge only.
    for (int i = 0; i < 4; i++) drive(LG);
    check("sg_g4_tim", 32'(err_timing), 0);
    check("sg_g4_dwell", dwell_cnt, 4);
    drive(LY);
    check("sg_y_tim", 32'(err_timing), 1);
    check("sg_y_seq", 32'(err_seq), 0);
    check("sg_y_phase", 32'(phase), 3);
    check("sg_sticky", 32'(err_sticky), 1);
    for (int i = 0; i < 4; i++) drive(LY);
    check("sg_y_tim_clear", 32'(err_timing), 0);

    // Overrun in RED: pulse on the 6th sample only.
    for (int i = 1; i <= 7; i++) begin
      drive(LR);
      check($sformatf("ov_r%0d_tim", i), 32'(err_timing), (i == 6) ? 1 : 0);
    end
    check("ov_dwell7", dwell_cnt, 7);
    check("ov_cycle", 32'(cycle_cnt), 2);

    // Illegal R->Y resync; the resynced Y is exempt from timing.
    for (int i = 0; i < 5; i++) drive(LG);
    for (int i = 0; i < 5; i++) drive(LY);
    for (int i = 0; i < 5; i++) drive(LR);
    check("sq_cycle3", 32'(cycle_cnt), 3);
    drive(LY);
    check("sq_seq", 32'(err_seq), 1);
    check("sq_tim", 32'(err_timing), 0);
    check("sq_phase", 32'(phase), 3);
    drive(LY);
    drive(LR);
    check("sq_exempt_tim", 32'(err_timing), 0);
    check("sq_yr_seq", 32'(err_seq), 0);
    check("sq_cycle4", 32'(cycle_cnt), 4);

    // Non-one-hot lamps mid-GREEN.
    for (int i = 0; i < 4; i++) drive(LR);
    drive(LG);
    drive(LG);
    drive(LRG);
    check("oh_pulse", 32'(err_onehot), 1);
    check("oh_phase", 32'(phase), 0);
    check("oh_dwell", dwell_cnt, 0);
    check("oh_seq", 32'(err_seq), 0);
    drive(LG);
    check("oh_g_phase", 32'(phase), 2);
    check("oh_g_dwell", dwell_cnt, 1);
    check("oh_g_chg", 32'(phase_chg), 1);
    check("oh_g_eoh", 32'(err_onehot), 0);
    drive(LG);
    drive(LY);
    check("oh_exempt_tim", 32'(err_timing), 0);
    drive(LY, 1'b1);
    check("clr_sticky", 32'(err_sticky), 0);
    check("clr_cycle", 32'(cycle_cnt), 0);
    // Y->R with clr: increment and error both beat clr.
    drive(LR, 1'b1);
    check("clr_inc_cycle", 32'(cycle_cnt), 1);
    check("clr_inc_tim", 32'(err_timing), 1);
    check("clr_inc_sticky", 32'(err_sticky), 1);

    // Asynchronous reset mid-GREEN.
    for (int i = 0; i < 4; i++) drive(LR);
    for (int i = 0; i < 3; i++) drive(LG);
    check("ar_pre_dwell", dwell_cnt, 3);
    #2 rst = 1'b0;
    #1;
    check("ar_phase", 32'(phase), 0);
    check("ar_dwell", dwell_cnt, 0);
    check("ar_sticky", 32'(err_sticky), 0);
    check("ar_cycle", 32'(cycle_cnt), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("ar_hold_phase", 32'(phase), 0);
    #3 rst = 1'b1;
    drive(LG);
    check("ar_g_phase", 32'(phase), 2);
    check("ar_g_dwell", dwell_cnt, 1);
    check("ar_g_chg", 32'(phase_chg), 1);
    drive(LY);
    check("ar_y_tim", 32'(err_timing), 0);
    check("ar_y_seq", 32'(err_seq), 0);
    check("ar_y_sticky", 32'(err_sticky), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
